ofmap_unchaining: RTL and testbench
===================================

OFMAP_UNCHAINING -- requirements
Module: ofmap_unchaining

Interface
REQ-001 SHALL have parameter OC0, default 4, number of 16-bit lanes per chained word.
REQ-002 SHALL have parameter COUNTER_WID, default 4, lane-index counter width; must satisfy 2^COUNTER_WID >= OC0.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port en_output, input, 1, global enable; low freezes the block.
REQ-006 SHALL have port chained_dat, input, 16*OC0, wide word; lane i = bits [(i+1)*16-1 : i*16].
REQ-007 SHALL have port chained_vld, input, 1, wide word valid.
REQ-008 SHALL have port chained_rdy, output, 1, block can accept a wide word.
REQ-009 SHALL have port ofmap_dat, output, 16, serialized lane.
REQ-010 SHALL have port ofmap_vld, output, 1, ofmap_dat valid.
REQ-011 SHALL have port ofmap_rdy, input, 1, downstream accepts ofmap_dat.
REQ-012 SHALL have port ofmap_last, output, 1, current lane is lane OC0-1.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after a whole word has drained.

Function
REQ-014 SHALL have two states: IDLE (no word held) and SEND (word held, lanes pending).
REQ-015 SHALL define capture as chained_vld && chained_rdy; on capture, latch chained_dat into a 16*OC0 holding register, set lane count 0, go to SEND.
REQ-016 SHALL drive chained_rdy = rst_n && en_output && state==IDLE (extended only by REQ-029).
REQ-017 SHALL drive ofmap_vld = en_output && state==SEND, and ofmap_dat = holding lane[count]; first lane valid the cycle after capture (latency 1).
REQ-018 SHALL emit lanes low-first: lane 0, lane 1, ..., lane OC0-1.
REQ-019 SHALL define transfer as ofmap_vld && ofmap_rdy; count advances only on transfer.
REQ-020 SHALL hold ofmap_dat and count stable while ofmap_vld && !ofmap_rdy.
REQ-021 SHALL, on transfer with count < OC0-1, increment count.
REQ-022 SHALL, on transfer with count == OC0-1, set count to 0 and go to IDLE (unless REQ-029 applies).
REQ-023 SHALL drive ofmap_last = ofmap_vld && count==OC0-1.
REQ-024 SHALL register done high for exactly the cycle after the final-lane transfer, low otherwise.
REQ-025 SHALL, with en_output low, force chained_rdy=0 and ofmap_vld=0 and hold state, count and holding register; resume on the same lane.

Reset
REQ-026 SHALL, while rst_n low at posedge, set state IDLE, count 0, holding register 0, done 0; chained_rdy, ofmap_vld, ofmap_last read 0 and ofmap_dat reads 0x0000.
REQ-027 SHALL, on reset mid-word, discard the remaining lanes with no done pulse.

Configuration
REQ-028 SHALL support macro OFMAP_UNCHAIN_PREFETCH_EN.
REQ-029 SHALL, when the macro is defined, also assert chained_rdy when state==SEND && count==OC0-1 && ofmap_rdy && en_output; capture in that cycle reloads the holding register, sets count 0, and stays in SEND, giving gap-free output; done still pulses.
REQ-030 SHALL, when the macro is undefined, accept only in IDLE, giving one idle ofmap cycle between consecutive words.

Structure
REQ-031 SHALL place the state enum (IDLE, SEND) and localparam LANE_WID=16 in shared package unchain_pkg.
REQ-032 SHALL implement the lane index with the existing counter module (MAX_COUNT=OC0, COUNTER_WID), enabled on transfer and cleared by reset.

Verification
REQ-033 SHALL cover single word: chained_dat=0x0004_0003_0002_0001, ofmap_rdy=1 -> ofmap_dat 0x0001,0x0002,0x0003,0x0004 on cycles 1-4 after capture, ofmap_last on cycle 4, done on cycle 5.
REQ-034 SHALL cover backpressure: ofmap_rdy=0 for 3 cycles while lane 2 is shown -> ofmap_dat stays 0x0003, ofmap_vld stays 1, and 0x0004 follows the cycle after ofmap_rdy returns.
REQ-035 SHALL cover back-to-back: two words with chained_vld held 1 and ofmap_rdy=1 -> 8 contiguous valid cycles with macro; one ofmap_vld=0 gap between lanes 3 and 4 without macro.
REQ-036 SHALL cover enable drop: en_output=0 for 2 cycles while lane 1 is shown -> ofmap_vld=0 and chained_rdy=0; lane 1 (0x0002) is re-presented when en_output returns.
REQ-037 SHALL cover mid-word reset: rst_n=0 for 1 cycle after lane 1 transfers -> ofmap_vld=0, no done pulse, chained_rdy=1 the first cycle after release, next word starts at lane 0.

Source files
------------

// File: rtl/unchain_pkg.sv
// rtl/unchain_pkg.sv - shared lane width and FSM state encoding for ofmap unchaining
package unchain_pkg;

  localparam int LANE_WID = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - wrapping index counter, 0..MAX_COUNT-1, advances when en is high
module counter #(
  parameter int MAX_COUNT   = 4,
  parameter int COUNTER_WID = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [COUNTER_WID-1:0] count,
  output logic                   at_max
);

  assign at_max = (count == COUNTER_WID'(MAX_COUNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ofmap_unchaining.sv
// rtl/ofmap_unchaining.sv - serializes an OC0-lane wide word into 16-bit lanes, low lane first
// Optional OFMAP_UNCHAIN_PREFETCH_EN: accept the next word during the final-lane transfer.
module ofmap_unchaining
  import unchain_pkg::*;
#(
  parameter int OC0         = 4,
  parameter int COUNTER_WID = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_output,
  input  logic [LANE_WID*OC0-1:0] chained_dat,
  input  logic                    chained_vld,
  output logic                    chained_rdy,
  output logic [LANE_WID-1:0]     ofmap_dat,
  output logic                    ofmap_vld,
  input  logic                    ofmap_rdy,
  output logic                    ofmap_last,
  output logic                    done
);

  state_t                  state_q, state_d;
  logic [LANE_WID*OC0-1:0] hold_q;
  logic                    done_q;
  logic [COUNTER_WID-1:0]  count;
  logic                    last_lane;
  logic                    xfer;
  logic                    capture;

  assign ofmap_vld = en_output && (state_q == SEND);
  assign xfer      = ofmap_vld && ofmap_rdy;

`ifdef OFMAP_UNCHAIN_PREFETCH_EN
  // Refill the holding register on the same edge the final lane leaves.
  assign chained_rdy = rst_n && en_output &&
                       ((state_q == IDLE) || ((state_q == SEND) && last_lane && ofmap_rdy));
`else
  assign chained_rdy = rst_n && en_output && (state_q == IDLE);
`endif

  assign capture    = chained_vld && chained_rdy;
  assign ofmap_last = ofmap_vld && last_lane;
  assign done       = done_q;

  counter #(
    .MAX_COUNT  (OC0),
    .COUNTER_WID(COUNTER_WID)
  ) u_lane_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .count (count),
    .at_max(last_lane)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (xfer && last_lane) state_d = capture ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) hold_q <= chained_dat;
      done_q <= xfer && last_lane;
    end
  end

  always_comb begin
    ofmap_dat = '0;
    for (int i = 0; i < OC0; i++) begin
      if (count == COUNTER_WID'(i)) ofmap_dat = hold_q[i*LANE_WID +: LANE_WID];
    end
  end

endmodule

// File: tb/tb_ofmap_unchaining.sv
// tb/tb_ofmap_unchaining.sv - directed self-checking bench for ofmap_unchaining
module tb_ofmap_unchaining;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_output;
  logic [63:0] chained_dat;
  logic        chained_vld;
  logic        chained_rdy;
  logic [15:0] ofmap_dat;
  logic        ofmap_vld;
  logic        ofmap_rdy;
  logic        ofmap_last;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [63:0] WORD_A = 64'h0004_0003_0002_0001;
  localparam logic [63:0] WORD_B = 64'h0008_0007_0006_0005;
  localparam logic [63:0] WORD_C = 64'h000c_000b_000a_0009;

  ofmap_unchaining #(.OC0(4), .COUNTER_WID(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_output  (en_output),
    .chained_dat(chained_dat),
    .chained_vld(chained_vld),
    .chained_rdy(chained_rdy),
    .ofmap_dat  (ofmap_dat),
    .ofmap_vld  (ofmap_vld),
    .ofmap_rdy  (ofmap_rdy),
    .ofmap_last (ofmap_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] w);
    chained_dat = w;
    chained_vld = 1'b1;
    tick();
    chained_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic        exp_vld [9];
  logic [15:0] exp_dat [9];

  initial begin
`ifdef OFMAP_UNCHAIN_PREFETCH_EN
    exp_vld = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    exp_dat = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'h0};
`else
    exp_vld = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    exp_dat = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h5, 16'h6, 16'h7, 16'h8};
`endif
    rst_n = 1'b0; en_output = 1'b1; chained_dat = '0; chained_vld = 1'b0; ofmap_rdy = 1'b1;
    tick(); tick();
    check("rst_chained_rdy", 32'(chained_rdy), 0);
    check("rst_ofmap_vld",   32'(ofmap_vld), 0);
    check("rst_ofmap_last",  32'(ofmap_last), 0);
    check("rst_ofmap_dat",   32'(ofmap_dat), 0);
    check("rst_done",        32'(done), 0);
    rst_n = 1'b1;
    #1;
    check("idle_chained_rdy", 32'(chained_rdy), 1);

    // single word, no backpressure
    load(WORD_A);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("single_vld%0d", i),  32'(ofmap_vld), 1);
      check($sformatf("single_dat%0d", i),  32'(ofmap_dat), 32'(i + 1));
      check($sformatf("single_last%0d", i), 32'(ofmap_last), (i == 3) ? 1 : 0);
      check($sformatf("single_done%0d", i), 32'(done), 0);
      tick();
    end
    check("single_done", 32'(done), 1);
    check("single_vld_after", 32'(ofmap_vld), 0);
    tick();
    check("single_done_clear", 32'(done), 0);

    // backpressure on lane 2
    load(WORD_A);
    tick(); tick();
    ofmap_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_dat%0d", k), 32'(ofmap_dat), 32'h3);
      check($sformatf("bp_vld%0d", k), 32'(ofmap_vld), 1);
      tick();
    end
    ofmap_rdy = 1'b1;
    #1;
    check("bp_dat_release", 32'(ofmap_dat), 32'h3);
    tick();
    check("bp_dat_next",  32'(ofmap_dat), 32'h4);
    check("bp_last_next", 32'(ofmap_last), 1);
    tick();
    check("bp_done", 32'(done), 1);
    tick();

    // back-to-back words with chained_vld held
    chained_dat = WORD_A;
    chained_vld = 1'b1;
    tick();
    chained_dat = WORD_B;
    for (int c = 0; c < 9; c++) begin
      logic cap;
      #1;
      cap = chained_vld && chained_rdy;
      check($sformatf("b2b_vld%0d", c + 1), 32'(ofmap_vld), 32'(exp_vld[c]));
      if (exp_vld[c]) check($sformatf("b2b_dat%0d", c + 1), 32'(ofmap_dat), 32'(exp_dat[c]));
      if (c == 4) check("b2b_done_a", 32'(done), 1);
      tick();
      if (cap) chained_vld = 1'b0;
    end
    check("b2b_vld_dropped", 32'(chained_vld), 0);
    tick(); tick(); tick();

    // enable drop while lane 1 is shown
    load(WORD_A);
    tick();
    check("en_lane1_dat", 32'(ofmap_dat), 32'h2);
    en_output = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("en_off_vld%0d", k), 32'(ofmap_vld), 0);
      check($sformatf("en_off_rdy%0d", k), 32'(chained_rdy), 0);
      tick();
    end
    en_output = 1'b1;
    #1;
    check("en_resume_vld", 32'(ofmap_vld), 1);
    check("en_resume_dat", 32'(ofmap_dat), 32'h2);
    tick(); tick(); tick();
    check("en_done", 32'(done), 1);
    tick();

    // reset mid-word after lane 1 transfers
    load(WORD_C);
    check("mr_lane0", 32'(ofmap_dat), 32'h9);
    tick(); tick();
    check("mr_lane2", 32'(ofmap_dat), 32'hb);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_vld",  32'(ofmap_vld), 0);
    check("mr_done", 32'(done), 0);
    check("mr_rdy",  32'(chained_rdy), 1);
    tick();
    check("mr_done_later", 32'(done), 0);
    load(WORD_A);
    check("mr_next_dat",  32'(ofmap_dat), 32'h1);
    check("mr_next_last", 32'(ofmap_last), 0);
    tick(); tick(); tick(); tick();
    check("mr_next_done", 32'(done), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
